// File: rtl/pb_err_slv_tile.sv
// Terminating AXI4 responder for unmapped mesh positions: every accepted read/write
// completes with DECERR, and a saturating counter tracks completed error transactions.
module pb_err_slv_tile #(
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned UserWidth = 1,
    parameter int unsigned CntWidth  = 32,
    parameter logic [63:0] RespData  = 64'hBADC_AB1E_BADC_AB1E
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [7:0]           aw_len_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    output logic [UserWidth-1:0] b_user_o,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    output logic [UserWidth-1:0] r_user_o,
    output logic [CntWidth-1:0]  err_cnt_o
);

    localparam logic [1:0]           RespDecErr = 2'b11;
    localparam logic [DataWidth-1:0] RespBeat   = RespData[DataWidth-1:0];

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wState_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rState_e;

    wState_e              r_wState;
    logic                 r_awReady;
    logic                 r_wReady;
    logic                 r_bValid;
    logic [IdWidth-1:0]   r_bId;

    rState_e              r_rState;
    logic                 r_arReady;
    logic                 r_rValid;
    logic                 r_rLast;
    logic [IdWidth-1:0]   r_rId;
    logic [7:0]           r_len;
    logic [7:0]           r_beatCnt;

    logic [CntWidth-1:0]  r_errCnt;

    logic                 w_awHs;
    logic                 w_wLastHs;
    logic                 w_bHs;
    logic                 w_arHs;
    logic                 w_rHs;
    logic                 w_rLastHs;
    logic [1:0]           w_incr;
    logic [CntWidth:0]    w_cntSum;
    logic                 w_unusedAwLen;

    // Burst length on the write side is never trusted; wlast alone ends the burst.
    assign w_unusedAwLen = ^aw_len_i;

    assign w_awHs    = aw_valid_i & r_awReady;
    assign w_wLastHs = w_valid_i & r_wReady & w_last_i;
    assign w_bHs     = r_bValid & b_ready_i;
    assign w_arHs    = ar_valid_i & r_arReady;
    assign w_rHs     = r_rValid & r_ready_i;
    assign w_rLastHs = w_rHs & r_rLast;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wState  <= W_IDLE;
            r_awReady <= 1'b1;
            r_wReady  <= 1'b0;
            r_bValid  <= 1'b0;
            r_bId     <= '0;
        end else begin
            case (r_wState)
                W_IDLE: begin
                    if (w_awHs) begin
                        r_wState  <= W_DATA;
                        r_bId     <= aw_id_i;
                        r_awReady <= 1'b0;
                        r_wReady  <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_wLastHs) begin
                        r_wState <= W_RESP;
                        r_wReady <= 1'b0;
                        r_bValid <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (w_bHs) begin
                        r_wState  <= W_IDLE;
                        r_bValid  <= 1'b0;
                        r_awReady <= 1'b1;
                    end
                end
                default: begin
                    r_wState  <= W_IDLE;
                    r_awReady <= 1'b1;
                    r_wReady  <= 1'b0;
                    r_bValid  <= 1'b0;
                end
            endcase
        end
    end

    // r_rLast is precomputed one beat ahead so the last flag is a plain register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rState  <= R_IDLE;
            r_arReady <= 1'b1;
            r_rValid  <= 1'b0;
            r_rLast   <= 1'b0;
            r_rId     <= '0;
            r_len     <= '0;
            r_beatCnt <= '0;
        end else begin
            case (r_rState)
                R_IDLE: begin
                    if (w_arHs) begin
                        r_rState  <= R_DATA;
                        r_rId     <= ar_id_i;
                        r_len     <= ar_len_i;
                        r_beatCnt <= '0;
                        r_rLast   <= (ar_len_i == 8'd0);
                        r_rValid  <= 1'b1;
                        r_arReady <= 1'b0;
                    end
                end
                R_DATA: begin
                    if (w_rHs) begin
                        if (r_rLast) begin
                            r_rState  <= R_IDLE;
                            r_rValid  <= 1'b0;
                            r_rLast   <= 1'b0;
                            r_arReady <= 1'b1;
                        end else begin
                            r_beatCnt <= r_beatCnt + 8'd1;
                            r_rLast   <= ((r_beatCnt + 8'd1) == r_len);
                        end
                    end
                end
                default: begin
                    r_rState  <= R_IDLE;
                    r_arReady <= 1'b1;
                    r_rValid  <= 1'b0;
                    r_rLast   <= 1'b0;
                end
            endcase
        end
    end

    assign w_incr   = {1'b0, w_bHs} + {1'b0, w_rLastHs};
    assign w_cntSum = {1'b0, r_errCnt} + (CntWidth+1)'(w_incr);

    // A carry out of the sum means we crossed all-ones; clamp there instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_errCnt <= '0;
        end else if (w_cntSum[CntWidth]) begin
            r_errCnt <= '1;
        end else begin
            r_errCnt <= w_cntSum[CntWidth-1:0];
        end
    end

    assign aw_ready_o = r_awReady;
    assign w_ready_o  = r_wReady;
    assign b_valid_o  = r_bValid;
    assign b_id_o     = r_bId;
    assign b_resp_o   = RespDecErr;
    assign b_user_o   = '0;
    assign ar_ready_o = r_arReady;
    assign r_valid_o  = r_rValid;
    assign r_id_o     = r_rId;
    assign r_data_o   = RespBeat;
    assign r_resp_o   = RespDecErr;
    assign r_last_o   = r_rLast;
    assign r_user_o   = '0;
    assign err_cnt_o  = r_errCnt;

endmodule

// File: tb/tb_pb_err_slv_tile.sv
// Scoreboard bench for pb_err_slv_tile: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them and tracks the error counter independently.
module tb_pb_err_slv_tile;

    localparam int unsigned IdWidth   = 4;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned UserWidth = 1;
    localparam int unsigned CntWidth  = 6;
    localparam logic [63:0] RespConst = 64'hBADC_AB1E_BADC_AB1E;
    localparam int          MaxCnt    = (1 << CntWidth) - 1;
    localparam int          Bound     = 5000;

    typedef struct {
        logic [IdWidth-1:0] id;
        logic               last;
    } rExp_t;

    logic                 clk;
    logic                 rst_ni;
    logic                 aw_valid_i;
    logic                 aw_ready_o;
    logic [IdWidth-1:0]   aw_id_i;
    logic [7:0]           aw_len_i;
    logic                 w_valid_i;
    logic                 w_ready_o;
    logic                 w_last_i;
    logic                 b_valid_o;
    logic                 b_ready_i;
    logic [IdWidth-1:0]   b_id_o;
    logic [1:0]           b_resp_o;
    logic [UserWidth-1:0] b_user_o;
    logic                 ar_valid_i;
    logic                 ar_ready_o;
    logic [IdWidth-1:0]   ar_id_i;
    logic [7:0]           ar_len_i;
    logic                 r_valid_o;
    logic                 r_ready_i;
    logic [IdWidth-1:0]   r_id_o;
    logic [DataWidth-1:0] r_data_o;
    logic [1:0]           r_resp_o;
    logic                 r_last_o;
    logic [UserWidth-1:0] r_user_o;
    logic [CntWidth-1:0]  err_cnt_o;

    int checks = 0;
    int errors = 0;
    int bRdyMode = 0;
    int rRdyMode = 0;

    logic [IdWidth-1:0] bExp[$];
    rExp_t              rExp[$];

    bit                 modelValid = 0;
    int                 modelCnt = 0;
    int                 ev;
    bit                 writeBusy, readBusy;
    bit                 prevAwHs, prevLastWHs, prevArHs, prevBStall, prevRStall;
    logic [IdWidth-1:0] prevBId, prevRId;
    logic               prevRLast;
    logic [IdWidth-1:0] bEnt;
    rExp_t              rEnt;

    pb_err_slv_tile #(
        .IdWidth   (IdWidth),
        .DataWidth (DataWidth),
        .UserWidth (UserWidth),
        .CntWidth  (CntWidth),
        .RespData  (RespConst)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .aw_valid_i (aw_valid_i),
        .aw_ready_o (aw_ready_o),
        .aw_id_i    (aw_id_i),
        .aw_len_i   (aw_len_i),
        .w_valid_i  (w_valid_i),
        .w_ready_o  (w_ready_o),
        .w_last_i   (w_last_i),
        .b_valid_o  (b_valid_o),
        .b_ready_i  (b_ready_i),
        .b_id_o     (b_id_o),
        .b_resp_o   (b_resp_o),
        .b_user_o   (b_user_o),
        .ar_valid_i (ar_valid_i),
        .ar_ready_o (ar_ready_o),
        .ar_id_i    (ar_id_i),
        .ar_len_i   (ar_len_i),
        .r_valid_o  (r_valid_o),
        .r_ready_i  (r_ready_i),
        .r_id_o     (r_id_o),
        .r_data_o   (r_data_o),
        .r_resp_o   (r_resp_o),
        .r_last_o   (r_last_o),
        .r_user_o   (r_user_o),
        .err_cnt_o  (err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out after %0d cycles at %0t", name, Bound, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset(input int n);
        rst_ni = 1'b0;
        repeat (n) step();
        rst_ni = 1'b1;
    endtask

    task automatic sendAw(input logic [IdWidth-1:0] id, input logic [7:0] len);
        int t = 0;
        bExp.push_back(id);
        aw_valid_i = 1'b1;
        aw_id_i    = id;
        aw_len_i   = len;
        while (aw_ready_o !== 1'b1 && t < Bound) begin
            step();
            t++;
        end
        if (t >= Bound) reportTimeout("awHandshake");
        step();
        aw_valid_i = 1'b0;
    endtask

    task automatic sendW(input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            if (gaps) repeat ($urandom_range(0, 3)) step();
            w_valid_i = 1'b1;
            w_last_i  = (k == n - 1);
            while (w_ready_o !== 1'b1 && t < Bound) begin
                step();
                t++;
            end
            if (t >= Bound) reportTimeout("wHandshake");
            step();
            w_valid_i = 1'b0;
            w_last_i  = 1'b0;
        end
    endtask

    task automatic sendAr(input logic [IdWidth-1:0] id, input logic [7:0] len);
        int t = 0;
        for (int k = 0; k <= int'(len); k++) begin
            rExp_t e;
            e.id   = id;
            e.last = (k == int'(len));
            rExp.push_back(e);
        end
        ar_valid_i = 1'b1;
        ar_id_i    = id;
        ar_len_i   = len;
        while (ar_ready_o !== 1'b1 && t < Bound) begin
            step();
            t++;
        end
        if (t >= Bound) reportTimeout("arHandshake");
        step();
        ar_valid_i = 1'b0;
    endtask

    task automatic waitIdle();
        int t = 0;
        while ((bExp.size() != 0 || rExp.size() != 0) && t < Bound) begin
            step();
            t++;
        end
        if (t >= Bound) reportTimeout("drainScoreboard");
        step();
    endtask

    task automatic applyStimulus(input int nTxn);
        bRdyMode = 1;
        rRdyMode = 1;
        fork
            begin
                repeat (nTxn) begin
                    logic [7:0] len;
                    len = 8'($urandom_range(0, 7));
                    sendAw(IdWidth'($urandom), len);
                    sendW(int'(len) + 1, 1'b1);
                end
            end
            begin
                repeat (nTxn) sendAr(IdWidth'($urandom), 8'($urandom_range(0, 15)));
            end
        join
        waitIdle();
        bRdyMode = 0;
        rRdyMode = 0;
    endtask

    // Ready drivers: 0 = held high, 1 = random, 2 = left to the stimulus thread.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bRdyMode == 0) b_ready_i = 1'b1;
            else if (bRdyMode == 1) b_ready_i = 1'($urandom_range(0, 1));
            if (rRdyMode == 0) r_ready_i = 1'b1;
            else if (rRdyMode == 1) r_ready_i = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: protocol expectations, scoreboard pops and a saturating counter model.
    always @(negedge clk) begin
        if (!rst_ni) begin
            bExp.delete();
            rExp.delete();
            writeBusy   = 0;
            readBusy    = 0;
            prevAwHs    = 0;
            prevLastWHs = 0;
            prevArHs    = 0;
            prevBStall  = 0;
            prevRStall  = 0;
            modelCnt    = 0;
            modelValid  = 1;
        end else begin
            if (modelValid) checkOutput("errCnt", 64'(err_cnt_o), 64'(modelCnt));
            checkOutput("awReadyIdle", 64'(aw_ready_o), 64'(!writeBusy));
            checkOutput("arReadyIdle", 64'(ar_ready_o), 64'(!readBusy));
            if (!writeBusy) begin
                checkOutput("wReadyNoAw", 64'(w_ready_o), 64'(0));
                checkOutput("bValidNoAw", 64'(b_valid_o), 64'(0));
            end
            if (!readBusy) checkOutput("rValidNoAr", 64'(r_valid_o), 64'(0));
            if (prevAwHs) checkOutput("wReadyAfterAw", 64'(w_ready_o), 64'(1));
            if (prevLastWHs) checkOutput("bValidAfterWlast", 64'(b_valid_o), 64'(1));
            if (prevArHs) checkOutput("rValidAfterAr", 64'(r_valid_o), 64'(1));
            if (prevBStall) begin
                checkOutput("bHoldValid", 64'(b_valid_o), 64'(1));
                checkOutput("bHoldId", 64'(b_id_o), 64'(prevBId));
            end
            if (prevRStall) begin
                checkOutput("rHoldValid", 64'(r_valid_o), 64'(1));
                checkOutput("rHoldId", 64'(r_id_o), 64'(prevRId));
                checkOutput("rHoldLast", 64'(r_last_o), 64'(prevRLast));
            end

            ev = 0;
            prevAwHs    = aw_valid_i && aw_ready_o;
            prevLastWHs = w_valid_i && w_ready_o && w_last_i;
            prevArHs    = ar_valid_i && ar_ready_o;
            prevBStall  = b_valid_o && !b_ready_i;
            prevRStall  = r_valid_o && !r_ready_i;
            prevBId     = b_id_o;
            prevRId     = r_id_o;
            prevRLast   = r_last_o;
            if (prevAwHs) writeBusy = 1;
            if (prevArHs) readBusy = 1;

            if (b_valid_o && b_ready_i) begin
                if (bExp.size() == 0) begin
                    checkOutput("unexpectedB", 64'(b_valid_o), 64'(0));
                end else begin
                    bEnt = bExp.pop_front();
                    checkOutput("bId", 64'(b_id_o), 64'(bEnt));
                    checkOutput("bResp", 64'(b_resp_o), 64'(2'b11));
                    checkOutput("bUser", 64'(b_user_o), 64'(0));
                    ev++;
                end
                writeBusy = 0;
            end
            if (r_valid_o && r_ready_i) begin
                if (rExp.size() == 0) begin
                    checkOutput("unexpectedR", 64'(r_valid_o), 64'(0));
                end else begin
                    rEnt = rExp.pop_front();
                    checkOutput("rId", 64'(r_id_o), 64'(rEnt.id));
                    checkOutput("rData", r_data_o, RespConst);
                    checkOutput("rResp", 64'(r_resp_o), 64'(2'b11));
                    checkOutput("rLast", 64'(r_last_o), 64'(rEnt.last));
                    checkOutput("rUser", 64'(r_user_o), 64'(0));
                    if (rEnt.last) begin
                        ev++;
                        readBusy = 0;
                    end
                end
            end
            modelCnt = (modelCnt + ev > MaxCnt) ? MaxCnt : modelCnt + ev;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_ni     = 1'b0;
        aw_valid_i = 1'b0;
        aw_id_i    = '0;
        aw_len_i   = '0;
        w_valid_i  = 1'b0;
        w_last_i   = 1'b0;
        b_ready_i  = 1'b1;
        ar_valid_i = 1'b0;
        ar_id_i    = '0;
        ar_len_i   = '0;
        r_ready_i  = 1'b1;

        applyReset(2);
        checkOutput("rstAwReady", 64'(aw_ready_o), 64'(1));
        checkOutput("rstArReady", 64'(ar_ready_o), 64'(1));
        checkOutput("rstWReady", 64'(w_ready_o), 64'(0));
        checkOutput("rstBValid", 64'(b_valid_o), 64'(0));
        checkOutput("rstRValid", 64'(r_valid_o), 64'(0));
        checkOutput("rstRLast", 64'(r_last_o), 64'(0));
        checkOutput("rstBId", 64'(b_id_o), 64'(0));
        checkOutput("rstRId", 64'(r_id_o), 64'(0));
        checkOutput("rstBResp", 64'(b_resp_o), 64'(2'b11));
        checkOutput("rstRResp", 64'(r_resp_o), 64'(2'b11));
        checkOutput("rstRData", r_data_o, RespConst);
        checkOutput("rstErrCnt", 64'(err_cnt_o), 64'(0));

        $display("[TB] single-beat read after reset");
        sendAr(4'd3, 8'd0);
        waitIdle();
        checkOutput("cntAfterFirstRead", 64'(err_cnt_o), 64'(1));

        $display("[TB] write burst with W gaps");
        sendAw(4'd5, 8'd3);
        sendW(4, 1'b1);
        waitIdle();
        checkOutput("cntAfterWrite", 64'(err_cnt_o), 64'(2));

        $display("[TB] 256-beat read with random backpressure");
        rRdyMode = 1;
        sendAr(4'd9, 8'd255);
        waitIdle();
        rRdyMode = 0;
        checkOutput("cntAfterLongRead", 64'(err_cnt_o), 64'(3));

        $display("[TB] W presented before AW");
        w_valid_i = 1'b1;
        w_last_i  = 1'b1;
        repeat (3) step();
        sendAw(4'd1, 8'd0);
        checkOutput("earlyWReady", 64'(w_ready_o), 64'(1));
        step();
        w_valid_i = 1'b0;
        w_last_i  = 1'b0;
        waitIdle();
        checkOutput("cntAfterEarlyW", 64'(err_cnt_o), 64'(4));

        $display("[TB] random concurrent traffic");
        applyStimulus(15);

        $display("[TB] simultaneous B and last R");
        applyReset(1);
        repeat (10) begin
            sendAr(IdWidth'($urandom), 8'd0);
            waitIdle();
        end
        checkOutput("cntTen", 64'(err_cnt_o), 64'(10));
        bRdyMode  = 2;
        rRdyMode  = 2;
        b_ready_i = 1'b0;
        r_ready_i = 1'b0;
        sendAw(4'd7, 8'd0);
        sendW(1, 1'b0);
        sendAr(4'd2, 8'd0);
        checkOutput("simBValid", 64'(b_valid_o), 64'(1));
        checkOutput("simRValid", 64'(r_valid_o), 64'(1));
        b_ready_i = 1'b1;
        r_ready_i = 1'b1;
        step();
        b_ready_i = 1'b0;
        r_ready_i = 1'b0;
        checkOutput("cntTwelve", 64'(err_cnt_o), 64'(12));
        bRdyMode = 0;
        rRdyMode = 0;
        waitIdle();

        $display("[TB] saturation");
        repeat (50) begin
            sendAr(IdWidth'($urandom), 8'd0);
            waitIdle();
        end
        checkOutput("cntMaxMinusOne", 64'(err_cnt_o), 64'(MaxCnt - 1));
        bRdyMode  = 2;
        rRdyMode  = 2;
        b_ready_i = 1'b0;
        r_ready_i = 1'b0;
        sendAw(4'd4, 8'd0);
        sendW(1, 1'b0);
        sendAr(4'd6, 8'd0);
        b_ready_i = 1'b1;
        r_ready_i = 1'b1;
        step();
        b_ready_i = 1'b0;
        r_ready_i = 1'b0;
        checkOutput("cntSatDouble", 64'(err_cnt_o), 64'(MaxCnt));
        bRdyMode = 0;
        rRdyMode = 0;
        waitIdle();
        sendAr(4'd8, 8'd0);
        waitIdle();
        checkOutput("cntSatHold", 64'(err_cnt_o), 64'(MaxCnt));

        $display("[TB] reset during read burst");
        sendAr(4'd11, 8'd7);
        step();
        step();
        checkOutput("midBurstBeat2Valid", 64'(r_valid_o), 64'(1));
        rst_ni = 1'b0;
        step();
        checkOutput("midRstRValid", 64'(r_valid_o), 64'(0));
        checkOutput("midRstArReady", 64'(ar_ready_o), 64'(1));
        checkOutput("midRstCnt", 64'(err_cnt_o), 64'(0));
        rst_ni = 1'b1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
